exc_handler: RTL
================

EXC_HANDLER -- requirements
Module: exc_handler

Interface
REQ-001 The block SHALL take parameter N, default 64, as the PC/ELR width in bits.
REQ-002 The block SHALL take parameter CW, default 8, as the exception-counter width in bits.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 Port pc_i  input  N  PC of the instruction executing this cycle.
REQ-006 Port exc_valid  input  1  decode reports invalid opcode this cycle.
REQ-007 Port ext_irq  input  1  external interrupt request, level, already synchronous to clk.
REQ-008 Port eret  input  1  current instruction is ERET.
REQ-009 Port pc_sel  output  2  select to downstream 4-input PC mux: 00 next PC, 01 exception vector, 10 ELR, 11 hold PC.
REQ-010 Port exc_taken  output  1  combinational pulse, exception accepted this cycle.
REQ-011 Port elr_o  output  N  exception link register.
REQ-012 Port esr_o  output  4  exception syndrome (cause code).
REQ-013 Port in_handler  output  1  registered, high while in HANDLER.
REQ-014 Port fatal  output  1  registered, high in FATAL.
REQ-015 Port exc_count  output  CW  saturating count of accepted exceptions.

Function
REQ-016 The FSM SHALL have states NORMAL, HANDLER and FATAL.
REQ-017 pc_sel and exc_taken SHALL be combinational from state and current inputs (zero latency); elr_o, esr_o, state, exc_count SHALL update at the next rising edge.
REQ-018 Cause codes SHALL be 4'h1 invalid opcode, 4'h2 external IRQ, 4'h3 ERET outside handler, 4'h0 none.
REQ-019 In NORMAL, event priority SHALL be exc_valid > eret > ext_irq; the highest-priority event sets exc_taken=1, pc_sel=01, loads elr_o<=pc_i, loads esr_o<=its cause, and moves to HANDLER.
REQ-020 In NORMAL with no event, pc_sel SHALL be 00 and all registers SHALL hold.
REQ-021 In HANDLER, ext_irq SHALL be ignored (masked); pc_sel=00 unless noted below.
REQ-022 In HANDLER, eret without exc_valid SHALL drive pc_sel=10 and move to NORMAL next edge; elr_o and esr_o SHALL hold.
REQ-023 In HANDLER, exc_valid (regardless of eret) SHALL be a double fault: pc_sel=11, exc_taken=0, elr_o/esr_o hold, state -> FATAL.
REQ-024 In FATAL, pc_sel SHALL be 11 and all inputs SHALL be ignored until reset.
REQ-025 exc_count SHALL increment by 1 on each edge where exc_taken=1 and SHALL saturate at 2^CW-1 without wrapping.
REQ-026 ext_irq held high across an ERET SHALL be accepted in the first NORMAL cycle after return (no lost, no duplicated acceptance in the ERET cycle).

Reset
REQ-027 On a rising edge with reset=0: state=NORMAL, elr_o=0, esr_o=4'h0, in_handler=0, fatal=0, exc_count=0; this SHALL override any event in that cycle, from any state.
REQ-028 While reset=0, pc_sel SHALL be 00 and exc_taken SHALL be 0.

Structure
REQ-029 State enum, cause codes and pc_sel encodings SHALL live in shared package exc_pkg, also used by the PC-mux wiring.
REQ-030 The saturating counter SHALL be a sub-module sat_counter (parameter width, inputs clk, reset, inc; output count).

Verification
REQ-031 Reset then pc_i=64'h40, exc_valid=1 for one cycle -> that cycle pc_sel=01, exc_taken=1; next edge elr_o=64'h40, esr_o=4'h1, in_handler=1, exc_count=1.
REQ-032 In HANDLER, eret=1 -> pc_sel=10 that cycle; next edge in_handler=0, elr_o still 64'h40.
REQ-033 NORMAL, pc_i=64'h80, exc_valid=1 and ext_irq=1 same cycle -> esr_o=4'h1; ext_irq held through the handler is ignored; after ERET, ext_irq still high -> accepted next cycle with esr_o=4'h2, elr_o=pc_i of that cycle.
REQ-034 NORMAL, eret=1 -> pc_sel=01, esr_o=4'h3; then exc_valid=1 in HANDLER -> pc_sel=11, fatal=1, pc_sel stays 11 for 10 cycles of random stimulus; reset=0 -> fatal=0, state NORMAL.
REQ-035 CW=2: four accepted exceptions (each followed by ERET) -> exc_count reads 1,2,3,3.
REQ-036 reset=0 asserted in the same cycle as exc_valid=1 in NORMAL -> exc_taken=0, pc_sel=00; after the edge elr_o=0, esr_o=0, exc_count=0.

Source files
------------

// File: rtl/exc_pkg.sv
// exc_pkg: shared state, cause-code and PC-mux select encodings for exception handling
package exc_pkg;
    typedef enum logic [1:0] {NORMAL, HANDLER, FATAL} state_t;
    typedef enum logic [1:0] {
        PC_NEXT = 2'b00,
        PC_VEC  = 2'b01,
        PC_ELR  = 2'b10,
        PC_HOLD = 2'b11
    } pc_sel_t;
    localparam logic [3:0] CAUSE_NONE = 4'h0;
    localparam logic [3:0] CAUSE_INV  = 4'h1;
    localparam logic [3:0] CAUSE_IRQ  = 4'h2;
    localparam logic [3:0] CAUSE_ERET = 4'h3;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [width-1:0] count
);
    always_ff @(posedge clk)
        count <= !reset ? '0 : (inc && count != '1) ? count + 1'b1 : count;
endmodule

// File: rtl/exc_handler.sv
// exc_handler: exception FSM driving the PC mux, link/syndrome registers and exception count
module exc_handler
    import exc_pkg::*;
#(
    parameter int N  = 64,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  pc_i,
    input  logic          exc_valid,
    input  logic          ext_irq,
    input  logic          eret,
    output logic [1:0]    pc_sel,
    output logic          exc_taken,
    output logic [N-1:0]  elr_o,
    output logic [3:0]    esr_o,
    output logic          in_handler,
    output logic          fatal,
    output logic [CW-1:0] exc_count
);
    state_t     state;
    logic [3:0] cause;

    // priority: invalid opcode > stray eret > interrupt
    always_comb begin
        cause     = exc_valid ? CAUSE_INV : eret ? CAUSE_ERET : ext_irq ? CAUSE_IRQ : CAUSE_NONE;
        exc_taken = reset && state == NORMAL && cause != CAUSE_NONE;
        pc_sel    = !reset           ? PC_NEXT :
                    state == FATAL   ? PC_HOLD :
                    state == HANDLER ? (exc_valid ? PC_HOLD : eret ? PC_ELR : PC_NEXT) :
                    exc_taken        ? PC_VEC  : PC_NEXT;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= NORMAL;
            elr_o      <= '0;
            esr_o      <= CAUSE_NONE;
            in_handler <= 1'b0;
            fatal      <= 1'b0;
        end else begin
            case (state)
                NORMAL: if (exc_taken) begin
                    state      <= HANDLER;
                    elr_o      <= pc_i;
                    esr_o      <= cause;
                    in_handler <= 1'b1;
                end
                HANDLER: if (exc_valid) begin
                    state      <= FATAL;
                    in_handler <= 1'b0;
                    fatal      <= 1'b1;
                end else if (eret) begin
                    state      <= NORMAL;
                    in_handler <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.width(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (exc_taken),
        .count (exc_count)
    );
endmodule
